// File: rtl/hermes_switch_control_pkg.sv
// Shared types for the Hermes switch control: port numbering, FSM states,
// and the small helpers used for round-robin wrap-around and XY routing.
package hermes_pkg;

    localparam int PORT_COUNT = 5;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        IDLE,
        ARBITRATE,
        ROUTE,
        GRANT
    } state_e;

    // (base + offset) mod 5, valid for base <= 4 and offset <= 5
    function automatic logic [2:0] wrap_port(input logic [2:0] base, input logic [2:0] offset);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        return (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
    endfunction

    function automatic port_e xy_route(input logic [15:0] dest, input logic [15:0] here);
        if (dest[15:8] > here[15:8]) return EAST;
        if (dest[15:8] < here[15:8]) return WEST;
        if (dest[7:0] > here[7:0])   return NORTH;
        if (dest[7:0] < here[7:0])   return SOUTH;
        return LOCAL;
    endfunction

endpackage

// File: rtl/hermes_switch_control_if.sv
// Bundle between the input buffers / crossbar and the switch control.
interface hermes_switch_control_if #(
    parameter int FLIT_SIZE = 32
);
    import hermes_pkg::*;

    logic [PORT_COUNT-1:0]                req_i;
    logic [PORT_COUNT-1:0]                sending_i;
    logic [PORT_COUNT-1:0][FLIT_SIZE-1:0] header_i;
    logic [PORT_COUNT-1:0]                req_ack_o;
    logic [PORT_COUNT-1:0]                out_en_o;
    logic [PORT_COUNT-1:0][2:0]           out_sel_o;
    logic [PORT_COUNT-1:0][2:0]           in_sel_o;

    modport master (
        output req_i, sending_i, header_i,
        input  req_ack_o, out_en_o, out_sel_o, in_sel_o
    );

    modport slave (
        input  req_i, sending_i, header_i,
        output req_ack_o, out_en_o, out_sel_o, in_sel_o
    );

endinterface

// File: rtl/hermes_switch_control_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_sel, wrapping mod 5.
module hermes_rr_arbiter
    import hermes_pkg::*;
(
    input  logic [PORT_COUNT-1:0] req,
    input  logic [2:0]            last_sel,
    output logic [2:0]            grant,
    output logic                  valid
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = 3'd0;
        valid = 1'b0;
        for (int k = PORT_COUNT; k >= 1; k--) begin
            if (req[wrap_port(last_sel, 3'(k))]) begin
                grant = wrap_port(last_sel, 3'(k));
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes router switch control: round-robin arbitration, XY routing and
// crossbar connection bookkeeping for the five router ports.
module hermes_switch_control
    import hermes_pkg::*;
#(
    parameter logic [15:0] ADDRESS   = 16'h0000,
    parameter int          FLIT_SIZE = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    hermes_switch_control_if.slave  bus
);

    state_e                     state, next_state;
    logic [2:0]                 sel, last_sel;
    port_e                      target;
    logic [PORT_COUNT-1:0]      out_en;
    logic [PORT_COUNT-1:0][2:0] out_sel, in_sel;
    logic [PORT_COUNT-1:0]      sending_q;

    logic [2:0]                 arb_grant;
    logic                       arb_valid;
    logic [FLIT_SIZE-1:0]       head_flit;
    port_e                      route_port;
    logic [PORT_COUNT-1:0]      sending_fall;
    logic [PORT_COUNT-1:0]      release_mask;
    logic [PORT_COUNT-1:0]      grant_mask;

    hermes_rr_arbiter u_arbiter (
        .req      (bus.req_i),
        .last_sel (last_sel),
        .grant    (arb_grant),
        .valid    (arb_valid)
    );

    assign head_flit    = bus.header_i[sel];
    assign route_port   = xy_route(head_flit[15:0], ADDRESS);
    assign sending_fall = sending_q & ~bus.sending_i;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (|bus.req_i) next_state = ARBITRATE;
            ARBITRATE: next_state = arb_valid ? ROUTE : IDLE;
            // Busy check uses the registered out_en, so a same-cycle release still counts as busy
            ROUTE:     next_state = out_en[route_port] ? IDLE : GRANT;
            GRANT:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Only tear down an output that is still owned by the input whose packet ended
    always_comb begin
        release_mask = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (sending_fall[i] && out_en[in_sel[i]] && (out_sel[in_sel[i]] == 3'(i)))
                release_mask[in_sel[i]] = 1'b1;
        end
    end

    always_comb begin
        grant_mask    = '0;
        bus.req_ack_o = '0;
        if (state == GRANT) begin
            grant_mask[target] = 1'b1;
            bus.req_ack_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sel       <= 3'd0;
            last_sel  <= 3'd4;
            target    <= EAST;
            out_en    <= '0;
            out_sel   <= '0;
            in_sel    <= '0;
            sending_q <= '0;
        end else begin
            state     <= next_state;
            sending_q <= bus.sending_i;
            out_en    <= (out_en & ~release_mask) | grant_mask;
            if (state == ARBITRATE && arb_valid) begin
                sel      <= arb_grant;
                last_sel <= arb_grant;
            end
            if (state == ROUTE)
                target <= route_port;
            if (state == GRANT) begin
                out_sel[target] <= sel;
                in_sel[sel]     <= target;
            end
        end
    end

    assign bus.out_en_o  = out_en;
    assign bus.out_sel_o = out_sel;
    assign bus.in_sel_o  = in_sel;

endmodule

// File: tb/tb_hermes_switch_control.sv
// Directed bench for hermes_switch_control at ADDRESS 16'h0101 (X=1, Y=1).
module tb_hermes_switch_control;
    import hermes_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hermes_switch_control_if #(.FLIT_SIZE(32)) bus ();

    hermes_switch_control #(
        .ADDRESS   (16'h0101),
        .FLIT_SIZE (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [15:0] header);
        bus.header_i[port] = {16'h0000, header};
        bus.req_i[port]    = 1'b1;
    endtask

    // Checks ack is low until ack_cycle, then one-hot on port; the buffer then
    // drops its request and starts sending, as a real input buffer would.
    task automatic expect_ack_at(input int port, input int ack_cycle);
        logic [4:0] exp_ack;
        for (int c = 1; c <= ack_cycle; c++) begin
            tick();
            exp_ack = (c == ack_cycle) ? (5'b00001 << port) : 5'b00000;
            checkOutput($sformatf("ack_p%0d_c%0d", port, c), {27'd0, bus.req_ack_o}, {27'd0, exp_ack});
        end
        bus.req_i[port]     = 1'b0;
        bus.sending_i[port] = 1'b1;
    endtask

    task automatic check_connection(input int port, input int tgt);
        checkOutput($sformatf("out_en_%0d", tgt),  {31'd0, bus.out_en_o[tgt]}, 32'd1);
        checkOutput($sformatf("out_sel_%0d", tgt), {29'd0, bus.out_sel_o[tgt]}, 32'(port));
        checkOutput($sformatf("in_sel_%0d", port), {29'd0, bus.in_sel_o[port]}, 32'(tgt));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_i     = '0;
        bus.sending_i = '0;
        bus.header_i  = '0;
        tick();
        tick();
        checkOutput("rst_ack",     {27'd0, bus.req_ack_o}, 32'd0);
        checkOutput("rst_out_en",  {27'd0, bus.out_en_o},  32'd0);
        checkOutput("rst_out_sel", {17'd0, bus.out_sel_o}, 32'd0);
        checkOutput("rst_in_sel",  {17'd0, bus.in_sel_o},  32'd0);
        rst = 1'b0;

        $display("[TB] LOCAL input to EAST, 3-cycle ack latency");
        applyStimulus(4, 16'h0201);
        expect_ack_at(4, 3);
        tick();
        checkOutput("l2e_ack_off", {27'd0, bus.req_ack_o}, 32'd0);
        checkOutput("l2e_out_en",  {27'd0, bus.out_en_o},  32'h01);
        check_connection(4, EAST);
        bus.sending_i[4] = 1'b0;
        tick();
        checkOutput("l2e_release", {27'd0, bus.out_en_o}, 32'h00);
        checkOutput("l2e_sel_hold", {29'd0, bus.out_sel_o[0]}, 32'd4);

        $display("[TB] XY routing to LOCAL, SOUTH, WEST");
        applyStimulus(4, 16'h0101);
        expect_ack_at(4, 3);
        tick();
        checkOutput("rt_local", {27'd0, bus.out_en_o}, 32'h10);
        check_connection(4, LOCAL);
        bus.sending_i[4] = 1'b0;
        tick();
        applyStimulus(3, 16'h0100);
        expect_ack_at(3, 3);
        tick();
        checkOutput("rt_south", {27'd0, bus.out_en_o}, 32'h08);
        check_connection(3, SOUTH);
        bus.sending_i[3] = 1'b0;
        tick();
        applyStimulus(1, 16'h0001);
        expect_ack_at(1, 3);
        tick();
        checkOutput("rt_west", {27'd0, bus.out_en_o}, 32'h02);
        check_connection(1, WEST);
        bus.sending_i[1] = 1'b0;
        tick();
        checkOutput("rt_clear", {27'd0, bus.out_en_o}, 32'h00);

        $display("[TB] all five inputs request at once");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 16'h0101);
        applyStimulus(1, 16'h0201);
        applyStimulus(2, 16'h0001);
        applyStimulus(3, 16'h0102);
        applyStimulus(4, 16'h0100);
        for (int c = 1; c <= 20; c++) begin
            logic [4:0] exp_ack;
            tick();
            exp_ack = ((c % 4) == 3) ? (5'b00001 << ((c - 3) / 4)) : 5'b00000;
            checkOutput($sformatf("all_ack_c%0d", c), {27'd0, bus.req_ack_o}, {27'd0, exp_ack});
            bus.req_i     = bus.req_i & ~exp_ack;
            bus.sending_i = bus.sending_i | exp_ack;
        end
        checkOutput("all_out_en",  {27'd0, bus.out_en_o},  32'h1f);
        checkOutput("all_in_sel",  {17'd0, bus.in_sel_o},  {17'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4});
        checkOutput("all_out_sel", {17'd0, bus.out_sel_o}, {17'd0, 3'd0, 3'd4, 3'd3, 3'd2, 3'd1});
        bus.sending_i[3] = 1'b0;
        bus.sending_i[4] = 1'b0;
        tick();
        checkOutput("two_release", {27'd0, bus.out_en_o}, 32'h13);

        $display("[TB] async reset with three live connections");
        #2;
        rst           = 1'b1;
        bus.sending_i = '0;
        bus.req_i     = '0;
        #1;
        checkOutput("async_out_en", {27'd0, bus.out_en_o},  32'h00);
        checkOutput("async_ack",    {27'd0, bus.req_ack_o}, 32'h00);
        tick();
        rst = 1'b0;
        applyStimulus(0, 16'h0100);
        expect_ack_at(0, 3);
        tick();
        checkOutput("post_rst_conn", {27'd0, bus.out_en_o}, 32'h08);
        bus.sending_i[0] = 1'b0;
        tick();

        $display("[TB] busy LOCAL output blocks WEST until release");
        applyStimulus(0, 16'h0101);
        expect_ack_at(0, 3);
        tick();
        checkOutput("e2l_conn", {27'd0, bus.out_en_o}, 32'h10);
        applyStimulus(1, 16'h0101);
        for (int c = 1; c <= 6; c++) begin
            tick();
            checkOutput($sformatf("busy_ack_c%0d", c), {27'd0, bus.req_ack_o}, 32'd0);
        end
        bus.sending_i[0] = 1'b0;
        tick();
        checkOutput("busy_release", {27'd0, bus.out_en_o},  32'h00);
        checkOutput("busy_ack_c7",  {27'd0, bus.req_ack_o}, 32'd0);
        tick();
        checkOutput("busy_ack_c8",  {27'd0, bus.req_ack_o}, 32'd0);
        tick();
        checkOutput("busy_ack_c9",  {27'd0, bus.req_ack_o}, 32'h02);
        bus.req_i[1]     = 1'b0;
        bus.sending_i[1] = 1'b1;
        tick();
        checkOutput("w2l_out_en", {27'd0, bus.out_en_o}, 32'h10);
        check_connection(1, LOCAL);

        $display("[TB] release and grant in the same cycle");
        applyStimulus(2, 16'h0201);
        expect_ack_at(2, 3);
        checkOutput("coinc_before", {27'd0, bus.out_en_o}, 32'h10);
        bus.sending_i[1] = 1'b0;
        tick();
        checkOutput("coinc_after", {27'd0, bus.out_en_o}, 32'h01);
        check_connection(2, EAST);

        $display("[TB] busy target does not block next requester");
        applyStimulus(3, 16'h0201);
        applyStimulus(4, 16'h0101);
        expect_ack_at(4, 6);
        tick();
        checkOutput("skip_out_en", {27'd0, bus.out_en_o},  32'h11);
        checkOutput("skip_ack_c7", {27'd0, bus.req_ack_o}, 32'd0);
        bus.sending_i[2] = 1'b0;
        tick();
        checkOutput("retry_ack_c8", {27'd0, bus.req_ack_o}, 32'd0);
        checkOutput("retry_out_en", {27'd0, bus.out_en_o},  32'h10);
        tick();
        checkOutput("retry_ack_c9", {27'd0, bus.req_ack_o}, 32'd0);
        tick();
        checkOutput("retry_ack_c10", {27'd0, bus.req_ack_o}, 32'h08);
        bus.req_i[3] = 1'b0;
        tick();
        checkOutput("retry_conn", {27'd0, bus.out_en_o}, 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
